// File: rtl/bbc_timing_pkg.sv
// Shared timing definitions for the 2 MHz / 1 MHz clock-enable generator.
package bbc_timing_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_STRETCH = 1'b1
    } stretch_state_e;

    localparam int DEFAULT_CLK_DIV = 16;

    // Extra ticks held after the access tick before the CPU may advance
    localparam logic [1:0] STALL_ALIGNED    = 2'd1;
    localparam logic [1:0] STALL_MISALIGNED = 2'd2;

endpackage

// File: rtl/mhz1_cycle_stretch_if.sv
// Bus between the address decoder / CPU side and the cycle-stretch block.
interface mhz1_cycle_stretch_if;
    logic mhz1_enable;
    logic stretch_en;
    logic cpu_clken;
    logic mhz1_clken;
    logic phase_1m;
    logic stretching;

    modport master (
        output mhz1_enable, stretch_en,
        input  cpu_clken, mhz1_clken, phase_1m, stretching
    );

    modport slave (
        input  mhz1_enable, stretch_en,
        output cpu_clken, mhz1_clken, phase_1m, stretching
    );
endinterface

// File: rtl/clken_divider.sv
// Divides the system clock down to a 2 MHz tick and derives the 1 MHz phase
// and the registered 1 MHz clock-enable pulse.
module clken_divider
    import bbc_timing_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clock,
    input  logic reset,
    output logic tick,
    output logic phase_1m,
    output logic mhz1_clken
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    assign tick = (div_cnt == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            phase_1m   <= 1'b0;
            mhz1_clken <= 1'b0;
        end else begin
            mhz1_clken <= 1'b0;
            if (tick) begin
                div_cnt    <= '0;
                phase_1m   <= ~phase_1m;
                // A 1 MHz edge is a tick where the phase was high going in
                mhz1_clken <= phase_1m;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/mhz1_cycle_stretch.sv
// CPU clock-enable generator that stalls 1 MHz peripheral accesses so each
// such bus cycle finishes on a 1 MHz edge.
module mhz1_cycle_stretch
    import bbc_timing_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic                       clock,
    input  logic                       reset,
    mhz1_cycle_stretch_if.slave        bus
);
    logic tick;
    logic phase_1m;
    logic mhz1_clken;

    stretch_state_e state, state_nxt;
    logic [1:0]     stall_cnt, stall_nxt;
    logic           cpu_clken_q, cpu_clken_nxt;
    logic           stretching_q, stretching_nxt;

    clken_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .phase_1m   (phase_1m),
        .mhz1_clken (mhz1_clken)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            stall_cnt    <= 2'd0;
            cpu_clken_q  <= 1'b0;
            stretching_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            stall_cnt    <= stall_nxt;
            cpu_clken_q  <= cpu_clken_nxt;
            stretching_q <= stretching_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        stall_nxt      = stall_cnt;
        cpu_clken_nxt  = 1'b0;
        stretching_nxt = stretching_q;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (bus.mhz1_enable && bus.stretch_en) begin
                        state_nxt      = ST_STRETCH;
                        stretching_nxt = 1'b1;
                        // Pre-toggle phase high: this tick is itself a 1 MHz edge,
                        // so the cycle must run on to the following edge.
                        stall_nxt      = phase_1m ? STALL_MISALIGNED : STALL_ALIGNED;
                    end else begin
                        cpu_clken_nxt = 1'b1;
                    end
                end
                ST_STRETCH: begin
                    if (stall_cnt == 2'd1) begin
                        state_nxt      = ST_IDLE;
                        stall_nxt      = 2'd0;
                        cpu_clken_nxt  = 1'b1;
                        stretching_nxt = 1'b0;
                    end else begin
                        stall_nxt = stall_cnt - 2'd1;
                    end
                end
                default: begin
                    state_nxt      = ST_IDLE;
                    stall_nxt      = 2'd0;
                    stretching_nxt = 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_clken  = cpu_clken_q;
    assign bus.stretching = stretching_q;
    assign bus.mhz1_clken = mhz1_clken;
    assign bus.phase_1m   = phase_1m;
endmodule

// File: tb/tb_mhz1_cycle_stretch.sv
// Self-checking bench: cycle-level reference model of the enable timing plus
// directed interval checks and a randomized access phase.
module tb_mhz1_cycle_stretch;
    localparam int DIV = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    mhz1_cycle_stretch_if bus();

    mhz1_cycle_stretch #(.CLK_DIV(DIV)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: clocks since release, 2 MHz tick index, and the tick on
    // which a pending stretched access releases (the next 1 MHz edge).
    int  t = 0, k = 0, rel = 0;
    bit  busy = 0;
    bit  e_cpu = 0, e_m = 0, e_ph = 0, e_str = 0;

    function automatic bit is_1m_edge(input int tk);
        return (tk > 0) && (tk % 2 == 0);
    endfunction

    function automatic int next_edge(input int tk);
        int j = tk + 1;
        while (!is_1m_edge(j)) j++;
        return j;
    endfunction

    always @(posedge clock) begin
        bit en, sen;
        en  = bus.mhz1_enable;
        sen = bus.stretch_en;
        if (reset) begin
            t = 0; k = 0; busy = 0;
            e_cpu = 0; e_m = 0; e_ph = 0; e_str = 0;
        end else begin
            t++;
            e_cpu = 0;
            e_m   = 0;
            if (t % DIV == 0) begin
                k    = t / DIV;
                e_m  = is_1m_edge(k);
                e_ph = k[0];
                if (busy) begin
                    if (k == rel) begin
                        e_cpu = 1; e_str = 0; busy = 0;
                    end
                end else if (en && sen) begin
                    busy = 1; rel = next_edge(k); e_str = 1;
                end else begin
                    e_cpu = 1;
                end
            end
        end
        #1;
        chk("cpu_clken",  bus.cpu_clken,  e_cpu);
        chk("mhz1_clken", bus.mhz1_clken, e_m);
        chk("phase_1m",   bus.phase_1m,   e_ph);
        chk("stretching", bus.stretching, e_str);
    end

    // Counts clocks until the next cpu_clken pulse and how many of them had
    // stretching high; an expired bound is reported as a failure.
    task automatic wait_cpu(output int clocks, output int str_clocks);
        clocks = 0;
        str_clocks = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clock);
            #1;
            clocks++;
            if (bus.stretching) str_clocks++;
            if (bus.cpu_clken) return;
        end
        chk("wait_cpu_timeout", 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gap, sc;
        bus.mhz1_enable = 1'b0;
        bus.stretch_en  = 1'b1;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_cpu_clken",  bus.cpu_clken, 0);
        chk("rst_mhz1_clken", bus.mhz1_clken, 0);
        chk("rst_phase_1m",   bus.phase_1m, 0);
        chk("rst_stretching", bus.stretching, 0);
        reset = 1'b0;

        // Plain running: first pulse 4 clocks after release, then every 4
        wait_cpu(gap, sc);
        chk("first_cpu_gap", gap, 4);
        wait_cpu(gap, sc);
        chk("idle_cpu_gap", gap, 4);

        // Access starting off a 1 MHz edge: one tick suppressed
        for (int i = 0; i < 4 && e_ph != 0; i++) wait_cpu(gap, sc);
        bus.mhz1_enable = 1'b1;
        wait_cpu(gap, sc);
        bus.mhz1_enable = 1'b0;
        chk("short_stretch_gap", gap, 8);
        chk("short_stretch_str", sc, 4);
        chk("short_stretch_aligned", bus.mhz1_clken, 1);

        // Access starting on a 1 MHz edge: two ticks suppressed
        for (int i = 0; i < 4 && e_ph != 1; i++) wait_cpu(gap, sc);
        bus.mhz1_enable = 1'b1;
        wait_cpu(gap, sc);
        bus.mhz1_enable = 1'b0;
        chk("long_stretch_gap", gap, 12);
        chk("long_stretch_str", sc, 8);
        chk("long_stretch_aligned", bus.mhz1_clken, 1);

        // Back-to-back 1 MHz accesses
        bus.mhz1_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_cpu(gap, sc);
            chk("b2b_aligned", bus.mhz1_clken, 1);
            if (i >= 2) chk("b2b_gap", gap, 8);
        end

        // Stretch disabled: never stalls
        bus.stretch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_cpu(gap, sc);
            chk("turbo_gap", gap, 4);
            chk("turbo_str", sc, 0);
        end

        // Reset two clocks into a stretch
        bus.stretch_en = 1'b1;
        begin
            bit seen = 0;
            for (int i = 0; i < 32 && !seen; i++) begin
                @(posedge clock);
                #1;
                seen = bus.stretching;
            end
            chk("enter_stretch", seen, 1);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midrst_cpu_clken",  bus.cpu_clken, 0);
        chk("midrst_mhz1_clken", bus.mhz1_clken, 0);
        chk("midrst_phase_1m",   bus.phase_1m, 0);
        chk("midrst_stretching", bus.stretching, 0);
        bus.mhz1_enable = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wait_cpu(gap, sc);
        chk("post_rst_gap", gap, 4);
        chk("post_rst_str", sc, 0);

        // Randomized access pattern against the model
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            bus.mhz1_enable = 1'($urandom_range(0, 1));
            bus.stretch_en  = ($urandom_range(0, 3) != 0);
        end

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
